// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state, quarter and sizing definitions for the I2C masters
package i2c_pkg;

  // Bus-phase states; each phase is four quarter ticks long.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } i2c_state_e;

  typedef logic [1:0] quarter_t;

  localparam quarter_t Q0 = 2'd0;
  localparam quarter_t Q1 = 2'd1;
  localparam quarter_t Q2 = 2'd2;
  localparam quarter_t Q3 = 2'd3;

  // Bytes on the wire: address byte, then register address, then data.
  function automatic int total_bytes(input int reg_bytes, input int data_bytes);
    return 1 + reg_bytes + data_bytes;
  endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// rtl/i2c_clk_div.sv - SCL quarter-period tick generator
module i2c_clk_div #(
  parameter int CLK_DIV = 125
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TERMINAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERMINAL);

  // Count 0..CLK_DIV-1 while enabled; a clear restarts the quarter from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERMINAL) ? '0 : cnt_q + CW'(1);
    end
  end

  // Divider register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_master_wr.sv
// rtl/i2c_master_wr.sv - I2C register-write master with per-byte ACK check
module i2c_master_wr
  import i2c_pkg::*;
#(
  parameter int CLK_DIV    = 125,
  parameter int REG_BYTES  = 1,
  parameter int DATA_BYTES = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic [6:0]              DEV_ADDR,
  input  logic [8*REG_BYTES-1:0]  REG_ADDR,
  input  logic [8*DATA_BYTES-1:0] WDATA,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ACK_ERR,
  output logic                    SCL,
  inout  wire                     SDA
);

  localparam int NBYTES = total_bytes(REG_BYTES, DATA_BYTES);
  localparam int FW = 8 * NBYTES;
  localparam int BCW = $clog2(NBYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  i2c_state_e     state_q, state_d;
  quarter_t       q_q, q_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ack_err_q, ack_err_d;
  logic           scl_q, scl_d;
  logic           sda_oe_q, sda_oe_d;
  logic           sda_meta_q, sda_meta_d;
  logic           sda_sync_q, sda_sync_d;
  logic           accept;
  logic           tick;
  logic [1:0]     drive;

  assign accept = START && !busy_q;

  i2c_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (busy_q),
    .clr  (accept),
    .tick (tick)
  );

  // Bus levels for a given phase/quarter, returned as {scl, sda_oe}.
  // SDA only moves while SCL is low, except the START and STOP edges.
  function automatic logic [1:0] bus_drive(input i2c_state_e st, input quarter_t qt,
                                           input logic tx_bit);
    logic scl_hi;
    scl_hi = (qt == Q1) || (qt == Q2);
    case (st)
      ST_START: bus_drive = (qt == Q0) ? 2'b10 : (qt == Q3) ? 2'b01 : 2'b11;
      ST_BIT:   bus_drive = {scl_hi, ~tx_bit};
      ST_ACK:   bus_drive = {scl_hi, 1'b0};
      ST_STOP:  bus_drive = (qt == Q0) ? 2'b01 : (qt == Q1) ? 2'b11 : 2'b10;
      default:  bus_drive = 2'b10;
    endcase
  endfunction

  // Phase sequencing, frame shifting, ACK sampling and registered bus drive.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    frame_d    = frame_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
    sda_meta_d = SDA;
    sda_sync_d = sda_meta_q;

    if (accept) begin
      state_d    = ST_START;
      q_d        = Q0;
      bit_cnt_d  = 3'd7;
      byte_cnt_d = '0;
      frame_d    = {DEV_ADDR, 1'b0, REG_ADDR, WDATA};
      ack_err_d  = 1'b0;
      busy_d     = 1'b1;
    end else if (tick) begin
      q_d = q_q + 2'd1;
      case (state_q)
        ST_START: begin
          if (q_q == Q3) begin
            state_d    = ST_BIT;
            bit_cnt_d  = 3'd7;
            byte_cnt_d = '0;
          end
        end
        ST_BIT: begin
          if (q_q == Q3) begin
            // The MSB of the frame is always the bit on the wire.
            frame_d   = {frame_q[FW-2:0], 1'b1};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              state_d = ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if ((q_q == Q2) && sda_sync_q) begin
            ack_err_d = 1'b1;
          end
          if (q_q == Q3) begin
            if (ack_err_q || (byte_cnt_q == LAST_BYTE)) begin
              state_d = ST_STOP;
            end else begin
              state_d    = ST_BIT;
              bit_cnt_d  = 3'd7;
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end
        end
        ST_STOP: begin
          if (q_q == Q3) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    drive    = bus_drive(state_d, q_d, frame_d[FW-1]);
    scl_d    = drive[1];
    sda_oe_d = drive[0];
  end

  // State and output registers; reset releases the bus at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      q_q        <= Q0;
      bit_cnt_q  <= 3'd7;
      byte_cnt_q <= '0;
      frame_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign SCL     = scl_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ACK_ERR = ack_err_q;

endmodule

// File: tb/tb_i2c_master_wr.sv
// tb/tb_i2c_master_wr.sv - self-checking bench for i2c_master_wr
`timescale 1ns/1ps
module tb_i2c_master_wr;

  localparam int NCFG = 5;

  function automatic int cfg_cd(input int i);
    case (i) 0: return 4; 1: return 4; 2: return 2; 3: return 3; default: return 125; endcase
  endfunction
  function automatic int cfg_rb(input int i);
    case (i) 0: return 1; 1: return 2; 2: return 1; 3: return 2; default: return 1; endcase
  endfunction
  function automatic int cfg_db(input int i);
    case (i) 0: return 1; 1: return 4; 2: return 2; 3: return 1; default: return 1; endcase
  endfunction

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  int          sel = 0;
  logic [6:0]  dev = '0;
  logic [15:0] regv = '0;
  logic [31:0] wdat = '0;
  logic        ack_drive = 1'b0;

  wire [NCFG-1:0] busy_v, done_v, aerr_v, scl_v, sda_v;
  logic scl_s, sda_s;
  assign scl_s = scl_v[sel];
  assign sda_s = sda_v[sel];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int CD = cfg_cd(g);
    localparam int RB = cfg_rb(g);
    localparam int DB = cfg_db(g);
    wire  sda;
    logic start_g;
    pullup (sda);
    assign sda = (ack_drive && (sel == g)) ? 1'b0 : 1'bz;
    assign start_g = start && (sel == g);
    assign sda_v[g] = sda;
    i2c_master_wr #(.CLK_DIV(CD), .REG_BYTES(RB), .DATA_BYTES(DB)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .START(start_g), .DEV_ADDR(dev),
      .REG_ADDR(regv[8*RB-1:0]), .WDATA(wdat[8*DB-1:0]),
      .BUSY(busy_v[g]), .DONE(done_v[g]), .ACK_ERR(aerr_v[g]),
      .SCL(scl_v[g]), .SDA(sda));
  end

  int n_checks = 0;
  int n_fail = 0;

  // Bus monitor / slave model state
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] shreg = '0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  bit   skip_high = 1'b1;
  int   cnt = 0, bitn = 0, byte_idx = 0, nack_at = -1;
  int   starts = 0, stops = 0, wchecks = 0, werrs = 0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_scl = scl_s; prev_sda = sda_s;
      cnt = 0; bitn = 0; byte_idx = 0; skip_high = 1'b1; ack_drive = 1'b0;
    end else begin
      if (scl_s && prev_scl && (sda_s != prev_sda)) begin
        if (!sda_s) begin
          starts++; bitn = 0; byte_idx = 0; skip_high = 1'b1;
        end else begin
          stops++;
        end
      end
      if (scl_s != prev_scl) begin
        if (scl_s) begin
          wchecks++;
          if (cnt != 2 * cfg_cd(sel)) werrs++;
          if (bitn < 8) begin
            shreg = {shreg[6:0], sda_s};
            bitn++;
            if (bitn == 8) got_q.push_back(shreg);
          end else begin
            bitn = 0;
            byte_idx++;
          end
        end else begin
          if (!skip_high) begin
            wchecks++;
            if (cnt != 2 * cfg_cd(sel)) werrs++;
          end
          skip_high = 1'b0;
          if (bitn == 8) ack_drive = (byte_idx != nack_at);
          else if (bitn == 0) ack_drive = 1'b0;
        end
        cnt = 1;
      end else begin
        cnt++;
      end
      prev_scl = scl_s; prev_sda = sda_s;
    end
  end

  // Reference: bytes on the wire and BUSY length, from the transaction rules.
  function automatic int build_exp(input int s, input logic [6:0] d, input logic [15:0] r,
                                   input logic [31:0] w, input int nk);
    exp_q.delete();
    exp_q.push_back({d, 1'b0});
    for (int k = cfg_rb(s) - 1; k >= 0; k--) exp_q.push_back(r[8*k +: 8]);
    for (int k = cfg_db(s) - 1; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
    if (nk >= 0) while (exp_q.size() > nk + 1) void'(exp_q.pop_back());
    return (8 + 36 * exp_q.size()) * cfg_cd(s);
  endfunction

  function automatic bit bytes_ok();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_mon();
    got_q.delete(); starts = 0; stops = 0; wchecks = 0; werrs = 0;
  endtask

  task automatic launch(input int s, input logic [6:0] d, input logic [15:0] r,
                        input logic [31:0] w, input int nk, output logic early, output logic ae0);
    sel = s; nack_at = nk; dev = d; regv = r; wdat = w;
    clear_mon();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    early = busy_v[s]; ae0 = aerr_v[s];
  endtask

  task automatic wait_idle(input int s, output int cyc, output int dn, output logic ae, output bit tmo);
    cyc = 0; dn = 0; ae = 1'b0; tmo = 1'b0;
    while (busy_v[s] === 1'b1) begin
      cyc++;
      if (done_v[s]) dn++;
      if (cyc > 40000) begin tmo = 1'b1; break; end
      @(negedge CLK);
    end
    if (done_v[s]) begin dn++; ae = aerr_v[s]; end
  endtask

  task automatic run_txn(input int s, input logic [6:0] d, input logic [15:0] r, input logic [31:0] w,
                         input int nk, output logic early, output logic ae0, output int cyc,
                         output int dn, output logic ae, output bit tmo);
    launch(s, d, r, w, nk, early, ae0);
    wait_idle(s, cyc, dn, ae, tmo);
    repeat (4) @(negedge CLK) if (done_v[s]) dn++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++; if (busy_v !== '0) begin n_fail++; $display("FAIL reset BUSY got %b expected 0", busy_v); end
    n_checks++; if (done_v !== '0) begin n_fail++; $display("FAIL reset DONE got %b expected 0", done_v); end
    n_checks++; if (aerr_v !== '0) begin n_fail++; $display("FAIL reset ACK_ERR got %b expected 0", aerr_v); end
    n_checks++; if (scl_v !== '1) begin n_fail++; $display("FAIL reset SCL got %b expected all 1", scl_v); end
    n_checks++; if (sda_v !== '1) begin n_fail++; $display("FAIL reset SDA got %b expected released", sda_v); end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic();
    int s, eb, cyc, dn; logic [6:0] d; logic [15:0] r; logic [31:0] w;
    logic early, ae0, ae; bit tmo;
    for (int i = 0; i < 3; i++) begin
      s = (i == 2) ? 1 : 0;
      d = (i == 0) ? 7'h3C : 7'($urandom);
      r = (i == 0) ? 16'h0012 : 16'($urandom);
      w = (i == 0) ? 32'h0000_00A5 : $urandom;
      eb = build_exp(s, d, r, w, -1);
      run_txn(s, d, r, w, -1, early, ae0, cyc, dn, ae, tmo);
      n_checks++; if (tmo) begin n_fail++; $display("FAIL basic[%0d] timeout waiting for BUSY low", i); end
      n_checks++; if (early !== 1'b1) begin n_fail++; $display("FAIL basic[%0d] BUSY after accept got %b expected 1", i, early); end
      n_checks++; if (cyc != eb) begin n_fail++; $display("FAIL basic[%0d] busy_cycles got %0d expected %0d", i, cyc, eb); end
      n_checks++; if (dn != 1) begin n_fail++; $display("FAIL basic[%0d] done_pulses got %0d expected 1", i, dn); end
      n_checks++; if (ae !== 1'b0) begin n_fail++; $display("FAIL basic[%0d] ACK_ERR got %b expected 0", i, ae); end
      n_checks++; if (!bytes_ok()) begin n_fail++; $display("FAIL basic[%0d] bytes got %p expected %p", i, got_q, exp_q); end
      n_checks++; if (starts != 1 || stops != 1) begin n_fail++; $display("FAIL basic[%0d] start/stop got %0d/%0d expected 1/1", i, starts, stops); end
      n_checks++; if (wchecks != 18 * exp_q.size() + 1 || werrs != 0) begin
        n_fail++; $display("FAIL basic[%0d] scl_phases got %0d (bad %0d) expected %0d (bad 0)", i, wchecks, werrs, 18 * exp_q.size() + 1);
      end
    end
  endtask

  task automatic test_nack();
    int s, nk, eb, cyc, dn; logic [6:0] d; logic [15:0] r; logic [31:0] w;
    logic early, ae0, ae; bit tmo;
    for (int i = 0; i < 2; i++) begin
      s  = i;
      nk = (i == 0) ? 0 : int'($urandom_range(0, 6));
      d  = (i == 0) ? 7'h3C : 7'($urandom);
      r  = (i == 0) ? 16'h0012 : 16'($urandom);
      w  = (i == 0) ? 32'h0000_00A5 : $urandom;
      eb = build_exp(s, d, r, w, nk);
      run_txn(s, d, r, w, nk, early, ae0, cyc, dn, ae, tmo);
      n_checks++; if (tmo || cyc != eb) begin n_fail++; $display("FAIL nack[%0d] busy_cycles got %0d expected %0d", i, cyc, eb); end
      n_checks++; if (dn != 1) begin n_fail++; $display("FAIL nack[%0d] done_pulses got %0d expected 1", i, dn); end
      n_checks++; if (ae !== 1'b1) begin n_fail++; $display("FAIL nack[%0d] ACK_ERR at DONE got %b expected 1", i, ae); end
      n_checks++; if (aerr_v[s] !== 1'b1) begin n_fail++; $display("FAIL nack[%0d] ACK_ERR held got %b expected 1", i, aerr_v[s]); end
      n_checks++; if (!bytes_ok()) begin n_fail++; $display("FAIL nack[%0d] bytes got %p expected %p", i, got_q, exp_q); end
      n_checks++; if (stops != 1) begin n_fail++; $display("FAIL nack[%0d] stops got %0d expected 1", i, stops); end
    end
    eb = build_exp(0, 7'h21, 16'h0044, 32'h0000_0066, -1);
    run_txn(0, 7'h21, 16'h0044, 32'h0000_0066, -1, early, ae0, cyc, dn, ae, tmo);
    n_checks++; if (ae0 !== 1'b0) begin n_fail++; $display("FAIL nack_clear ACK_ERR after accept got %b expected 0", ae0); end
    n_checks++; if (ae !== 1'b0 || cyc != eb) begin n_fail++; $display("FAIL nack_clear ack_err/cycles got %b/%0d expected 0/%0d", ae, cyc, eb); end
  endtask

  task automatic test_long();
    int eb, cyc, dn; logic early, ae0, ae; bit tmo;
    eb = build_exp(1, 7'h3C, 16'h3008, 32'hDEAD_BEEF, -1);
    run_txn(1, 7'h3C, 16'h3008, 32'hDEAD_BEEF, -1, early, ae0, cyc, dn, ae, tmo);
    n_checks++; if (tmo || cyc != 1040) begin n_fail++; $display("FAIL long busy_cycles got %0d expected 1040", cyc); end
    n_checks++; if (!bytes_ok() || eb != 1040) begin n_fail++; $display("FAIL long bytes got %p expected %p", got_q, exp_q); end
    n_checks++; if (dn != 1 || ae !== 1'b0) begin n_fail++; $display("FAIL long done/ack_err got %0d/%b expected 1/0", dn, ae); end
  endtask

  task automatic test_back_to_back();
    int eb, c2, dn; logic early, ae0, ae; bit tmo;
    eb = build_exp(0, 7'h3C, 16'h0012, 32'h0000_00A5, -1);
    launch(0, 7'h3C, 16'h0012, 32'h0000_00A5, -1, early, ae0);
    repeat (49) @(negedge CLK);
    dev = 7'h11; wdat = 32'h0000_0055; start = 1'b1;
    @(negedge CLK); start = 1'b0; dev = 7'h3C;
    wait_idle(0, c2, dn, ae, tmo);
    n_checks++; if (tmo || 50 + c2 != 464) begin n_fail++; $display("FAIL b2b first busy_cycles got %0d expected 464", 50 + c2); end
    n_checks++; if (!bytes_ok()) begin n_fail++; $display("FAIL b2b first bytes got %p expected %p", got_q, exp_q); end
    n_checks++; if (done_v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b DONE at idle got %b expected 1", done_v[0]); end
    eb = build_exp(0, 7'h3C, 16'h0012, 32'h0000_0055, -1);
    clear_mon();
    start = 1'b1;
    @(negedge CLK); start = 1'b0;
    n_checks++; if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b no_gap BUSY got %b expected 1", busy_v[0]); end
    wait_idle(0, c2, dn, ae, tmo);
    n_checks++; if (tmo || c2 != eb) begin n_fail++; $display("FAIL b2b second busy_cycles got %0d expected %0d", c2, eb); end
    n_checks++; if (!bytes_ok() || starts != 1 || stops != 1) begin n_fail++; $display("FAIL b2b second bytes got %p expected %p", got_q, exp_q); end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int eb, cyc, dn, waited; logic early, ae0, ae; bit tmo, found;
    launch(0, 7'h3C, 16'h0012, 32'h0000_00A5, -1, early, ae0);
    found = 1'b0; waited = 0;
    while (!found && waited < 3000) begin
      @(negedge CLK); waited++;
      if (byte_idx == 2 && bitn == 2 && scl_v[0] === 1'b0) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_mid third data bit not reached in %0d cycles", waited); end
    RST_N = 1'b0;
    #1;
    n_checks++; if (scl_v[0] !== 1'b1 || sda_v[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid bus got scl=%b sda=%b expected 1/1", scl_v[0], sda_v[0]); end
    n_checks++; if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy/done got %b/%b expected 0/0", busy_v[0], done_v[0]); end
    dn = 0;
    repeat (3) @(negedge CLK) if (done_v[0]) dn++;
    RST_N = 1'b1;
    repeat (2) @(negedge CLK) if (done_v[0]) dn++;
    n_checks++; if (dn != 0) begin n_fail++; $display("FAIL rst_mid done_pulses got %0d expected 0", dn); end
    eb = build_exp(0, 7'h3C, 16'h0012, 32'h0000_00A5, -1);
    run_txn(0, 7'h3C, 16'h0012, 32'h0000_00A5, -1, early, ae0, cyc, dn, ae, tmo);
    n_checks++; if (tmo || cyc != eb || dn != 1) begin n_fail++; $display("FAIL rst_mid after cycles/done got %0d/%0d expected %0d/1", cyc, dn, eb); end
    n_checks++; if (!bytes_ok()) begin n_fail++; $display("FAIL rst_mid after bytes got %p expected %p", got_q, exp_q); end
  endtask

  task automatic test_clkdiv();
    int s, eb, cyc, dn; logic [6:0] d; logic [15:0] r; logic [31:0] w;
    logic early, ae0, ae; bit tmo;
    for (int i = 0; i < 2; i++) begin
      s = 2 + int'($urandom_range(0, 2));
      d = 7'($urandom); r = 16'($urandom); w = $urandom;
      eb = build_exp(s, d, r, w, -1);
      run_txn(s, d, r, w, -1, early, ae0, cyc, dn, ae, tmo);
      n_checks++; if (tmo || cyc != eb) begin n_fail++; $display("FAIL clkdiv[%0d] div=%0d busy_cycles got %0d expected %0d", i, cfg_cd(s), cyc, eb); end
      n_checks++; if (!bytes_ok()) begin n_fail++; $display("FAIL clkdiv[%0d] bytes got %p expected %p", i, got_q, exp_q); end
      n_checks++; if (werrs != 0 || wchecks != 18 * exp_q.size() + 1) begin
        n_fail++; $display("FAIL clkdiv[%0d] scl_phases got %0d (bad %0d) expected %0d (bad 0)", i, wchecks, werrs, 18 * exp_q.size() + 1);
      end
      n_checks++; if (starts != 1 || stops != 1) begin n_fail++; $display("FAIL clkdiv[%0d] start/stop got %0d/%0d expected 1/1", i, starts, stops); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_nack();
    test_long();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
